// File: rtl/quadrature_tracker_pkg.sv
// Quadrature tracker shared types.
// Gray state order, transition lookup, count direction.
package quadrature_tracker_pkg;

  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_11 = 2'b11,
    Q_10 = 2'b10
  } gray_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [1:0] gray_fwd(
    input logic [1:0] q
  );
    logic [1:0] n;
    n = Q_00;
    unique case (q)
      Q_00: n = Q_01;
      Q_01: n = Q_11;
      Q_11: n = Q_10;
      Q_10: n = Q_00;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] gray_rev(
    input logic [1:0] q
  );
    logic [1:0] n;
    n = Q_00;
    unique case (q)
      Q_00: n = Q_10;
      Q_10: n = Q_11;
      Q_11: n = Q_01;
      Q_01: n = Q_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hysteresis_comparator.sv
// Signed hysteresis comparator with sticky armed flag.
// A swapped threshold pair freezes the channel.
module hysteresis_comparator #(
  parameter int W = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en,
  input  logic signed [W-1:0] sample,
  input  logic signed [W-1:0] lower,
  input  logic signed [W-1:0] upper,
  output logic                level,
  output logic                armed
);

  logic cfg_ok;
  logic above;
  logic below;

  assign cfg_ok = upper >= lower;
  assign above  = sample > upper;
  assign below  = sample < lower;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      level <= 1'b0;
      armed <= 1'b0;
    end else if (en && cfg_ok) begin
      if (above) begin
        level <= 1'b1;
        armed <= 1'b1;
      end else if (below) begin
        level <= 1'b0;
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrature_tracker.sv
// Two-stage quadrature decoder: hysteresis slicing, then
// saturating position / error accumulation onto an AXI stream.
module quadrature_tracker #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int ERR_WIDTH          = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold_a,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold_a,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold_b,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold_b,
  input  logic [4:0]                           FC_log_scale,
  input  logic                                 FC_invert,
  input  logic                                 FC_clear,
  input  logic                                 S_AXIS_tvalid,
  output logic                                 S_AXIS_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]        S_AXIS_tdata,
  output logic                                 M_AXIS_tvalid,
  input  logic                                 M_AXIS_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
  output logic [ERR_WIDTH-1:0]                 error_count
);
  import quadrature_tracker_pkg::*;

  localparam int H = S_AXIS_TDATA_WIDTH / 2;
  localparam int M = M_AXIS_TDATA_WIDTH;
  localparam logic signed [M:0] PMAX = {2'b00, {(M-1){1'b1}}};
  localparam logic signed [M:0] PMIN = {2'b11, {(M-1){1'b0}}};

  logic en;
  logic adv1;
  logic v1;
  logic lvl_a, lvl_b;
  logic arm_a, arm_b;
  logic signed [H-1:0] smp_a, smp_b;

  assign en            = ~M_AXIS_tvalid | M_AXIS_tready;
  assign S_AXIS_tready = en;
  assign adv1          = en & S_AXIS_tvalid;
  assign smp_a         = S_AXIS_tdata[H-1:0];
  assign smp_b         = S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:H];

  hysteresis_comparator #(.W(H)) u_cmp_a (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (adv1),
    .sample  (smp_a),
    .lower   (FC_lower_threshold_a),
    .upper   (FC_upper_threshold_a),
    .level   (lvl_a),
    .armed   (arm_a)
  );

  hysteresis_comparator #(.W(H)) u_cmp_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (adv1),
    .sample  (smp_b),
    .lower   (FC_lower_threshold_b),
    .upper   (FC_upper_threshold_b),
    .level   (lvl_b),
    .armed   (arm_b)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= S_AXIS_tvalid;
    end
  end

  logic [1:0]          q;
  logic [1:0]          prev;
  logic                both, fwd, rev, jump, err_inc;
  dir_e                dir;
  logic [4:0]          shamt;
  logic signed [M-1:0] position;
  logic signed [M-1:0] pos_n;
  logic signed [M:0]   pos_w, step_w, sum_w;

  always_comb begin
    q      = {lvl_b, lvl_a};
    both   = arm_a & arm_b;
    fwd    = q == gray_fwd(prev);
    rev    = q == gray_rev(prev);
    jump   = (q ^ prev) == 2'b11;
    dir    = (fwd ^ FC_invert) ? DIR_UP : DIR_DOWN;
    // Oversized scales clamp so one step never reaches the rails alone
    shamt  = (int'(FC_log_scale) >= M - 1) ? 5'(M - 2) : FC_log_scale;
    step_w = (M+1)'(1) << shamt;
    pos_w  = {position[M-1], position};
    sum_w  = (dir == DIR_UP) ? pos_w + step_w : pos_w - step_w;
    pos_n  = position;
    if (both && (fwd || rev)) begin
      if (sum_w > PMAX)      pos_n = PMAX[M-1:0];
      else if (sum_w < PMIN) pos_n = PMIN[M-1:0];
      else                   pos_n = sum_w[M-1:0];
    end
    err_inc = both & jump & ~&error_count;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      position      <= '0;
      error_count   <= '0;
      prev          <= Q_00;
    end else begin
      if (en) begin
        M_AXIS_tvalid <= v1;
        if (v1) begin
          prev         <= q;
          position     <= pos_n;
          M_AXIS_tdata <= FC_clear ? '0 : pos_n;
          if (err_inc) error_count <= error_count + 1'b1;
        end
      end
      // Clear wins over any same-cycle update
      if (FC_clear) begin
        position    <= '0;
        error_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_tracker.sv
// Randomised and directed bench for quadrature_tracker,
// with a phase-arithmetic reference model.
module tb_quadrature_tracker;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic signed [15:0] lo_a = -16'sd100, hi_a = 16'sd100;
  logic signed [15:0] lo_b = -16'sd100, hi_b = 16'sd100;
  logic [4:0]  ls = 5'd0;
  logic        inv = 1'b0, clr = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tready, s_tready8;
  logic        m_tready = 1'b1;
  logic        m_tvalid, m_tvalid8;
  logic [31:0] m_tdata;
  logic [7:0]  m_tdata8;
  logic [15:0] err;
  logic [7:0]  err8;

  quadrature_tracker dut (
    .aclk (aclk), .aresetn (aresetn),
    .FC_lower_threshold_a (lo_a), .FC_upper_threshold_a (hi_a),
    .FC_lower_threshold_b (lo_b), .FC_upper_threshold_b (hi_b),
    .FC_log_scale (ls), .FC_invert (inv), .FC_clear (clr),
    .S_AXIS_tvalid (s_tvalid), .S_AXIS_tready (s_tready),
    .S_AXIS_tdata (s_tdata),
    .M_AXIS_tvalid (m_tvalid), .M_AXIS_tready (m_tready),
    .M_AXIS_tdata (m_tdata), .error_count (err)
  );

  quadrature_tracker #(
    .M_AXIS_TDATA_WIDTH (8), .ERR_WIDTH (8)
  ) dut8 (
    .aclk (aclk), .aresetn (aresetn),
    .FC_lower_threshold_a (lo_a), .FC_upper_threshold_a (hi_a),
    .FC_lower_threshold_b (lo_b), .FC_upper_threshold_b (hi_b),
    .FC_log_scale (ls), .FC_invert (inv), .FC_clear (clr),
    .S_AXIS_tvalid (s_tvalid), .S_AXIS_tready (s_tready8),
    .S_AXIS_tdata (s_tdata),
    .M_AXIS_tvalid (m_tvalid8), .M_AXIS_tready (m_tready),
    .M_AXIS_tdata (m_tdata8), .error_count (err8)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  bit     la, lb, ara, arb;
  int     pph;
  longint pos32, pos8;
  int     e32, e8;
  longint exp32[$], exp8[$], got32[$], got8[$];
  int     PH[4] = '{0, 1, 3, 2};

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_tvalid && m_tready) got32.push_back(longint'($signed(m_tdata)));
      if (m_tvalid8 && m_tready) got8.push_back(longint'($signed(m_tdata8)));
    end
  end

  function automatic longint step_of(int w);
    int sh;
    sh = (int'(ls) >= w - 1) ? w - 2 : int'(ls);
    return longint'(1) << sh;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  function automatic int sinv(real deg);
    real r;
    r = 1000.0 * $sin(deg * 3.14159265358979 / 180.0);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  task automatic model(int a, int b);
    int ph, d, dr;
    if (int'(hi_a) >= int'(lo_a)) begin
      if (a > int'(hi_a)) begin la = 1; ara = 1; end
      else if (a < int'(lo_a)) begin la = 0; ara = 1; end
    end
    if (int'(hi_b) >= int'(lo_b)) begin
      if (b > int'(hi_b)) begin lb = 1; arb = 1; end
      else if (b < int'(lo_b)) begin lb = 0; arb = 1; end
    end
    ph = PH[{lb, la}];
    if (ara && arb) begin
      d = (ph - pph + 4) % 4;
      if (d == 1 || d == 3) begin
        dr = (d == 1) ? 1 : -1;
        if (inv) dr = -dr;
        pos32 = sat(pos32 + dr * step_of(32), 32);
        pos8  = sat(pos8 + dr * step_of(8), 8);
      end else if (d == 2) begin
        if (e32 < 65535) e32++;
        if (e8 < 255) e8++;
      end
    end
    pph = ph;
    exp32.push_back(pos32);
    exp8.push_back(pos8);
  endtask

  task automatic flush();
    got32.delete(); got8.delete(); exp32.delete(); exp8.delete();
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    s_tvalid = 1'b0; clr = 1'b0; m_tready = 1'b1;
    la = 0; lb = 0; ara = 0; arb = 0; pph = 0;
    pos32 = 0; pos8 = 0; e32 = 0; e8 = 0;
    flush();
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic send(int a, int b);
    bit acc;
    int n;
    s_tvalid = 1'b1;
    s_tdata  = {16'(b), 16'(a)};
    n = 0;
    acc = 0;
    while (!acc && n < 100) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk); #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (acc) model(a, b);
    else begin
      fails++;
      $display("FAIL send_timeout: tready=%0b required=1", s_tready);
    end
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++;
      $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
    tests++; if (m_tdata !== 32'd0) begin fails++;
      $display("FAIL reset_tdata: got %0d want 0", m_tdata); end
    tests++; if (err !== 16'd0) begin fails++;
      $display("FAIL reset_err: got %0d want 0", err); end
    tests++; if (s_tready !== 1'b1) begin fails++;
      $display("FAIL reset_s_tready: got %0b want 1", s_tready); end
    tests++; if (m_tdata8 !== 8'd0) begin fails++;
      $display("FAIL reset_tdata8: got %0d want 0", m_tdata8); end
  endtask

  task automatic test_sine(bit b_leads, bit inv_v, longint want);
    do_reset();
    inv = inv_v;
    for (int k = 0; k <= 48; k++) begin
      real p;
      p = 22.5 * k;
      send(sinv(p), b_leads ? sinv(p + 90.0) : sinv(p - 90.0));
    end
    drain();
    tests++; if (got32.size() !== 49) begin fails++;
      $display("FAIL sine_beats: got %0d want 49", got32.size()); end
    tests++; if (got32.size() == 0 || got32[$] !== want) begin fails++;
      $display("FAIL sine_pos lead=%0b inv=%0b: got %0d want %0d",
        b_leads, inv_v, got32.size() ? got32[$] : -999, want); end
    tests++; if (err !== 16'd0) begin fails++;
      $display("FAIL sine_err: got %0d want 0", err); end
    tests++; if (got32 != exp32) begin fails++;
      $display("FAIL sine_model: beat stream differs from model"); end
    inv = 1'b0;
  endtask

  task automatic test_error_sat();
    do_reset();
    send(-500, -500);
    send(500, 500);
    drain();
    tests++; if (got32.size() == 0 || got32[$] !== 0) begin fails++;
      $display("FAIL jump_pos: got %0d want 0",
        got32.size() ? got32[$] : -999); end
    tests++; if (err !== 16'd1) begin fails++;
      $display("FAIL jump_err: got %0d want 1", err); end
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) send(-500, -500);
      else send(500, 500);
    end
    drain();
    tests++; if (err8 !== 8'hff) begin fails++;
      $display("FAIL err_saturate: got %0d want 255", err8); end
    tests++; if (err !== 16'd261) begin fails++;
      $display("FAIL err_count: got %0d want 261", err); end
    tests++; if (got32 != exp32 || got8 != exp8) begin fails++;
      $display("FAIL err_model: beat stream differs from model"); end
  endtask

  task automatic test_pos_saturate();
    bit neg;
    do_reset();
    ls = 5'd5;
    send(-500, -500);
    for (int i = 0; i < 10; i++) begin
      unique case (i % 4)
        0: send(500, -500);
        1: send(500, 500);
        2: send(-500, 500);
        default: send(-500, -500);
      endcase
    end
    drain();
    neg = 0;
    foreach (got8[i]) if (got8[i] < 0) neg = 1;
    tests++; if (neg) begin fails++;
      $display("FAIL sat_negative: got negative=1 want 0"); end
    tests++; if (got8.size() == 0 || got8[$] !== 127) begin fails++;
      $display("FAIL sat_pos8: got %0d want 127",
        got8.size() ? got8[$] : -999); end
    tests++; if (got32.size() == 0 || got32[$] !== 320) begin fails++;
      $display("FAIL sat_pos32: got %0d want 320",
        got32.size() ? got32[$] : -999); end
    tests++; if (got8 != exp8) begin fails++;
      $display("FAIL sat_model: beat stream differs from model"); end
    ls = 5'd0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    send(-500, -500);
    drain();
    m_tready = 1'b0;
    send(500, -500);
    send(500, 500);
    fork
      send(-500, 500);
      begin
        @(negedge aclk);
        held = m_tdata;
        repeat (5) begin
          @(negedge aclk);
          tests++; if (s_tready !== 1'b0 || m_tvalid !== 1'b1 ||
                       m_tdata !== held) begin fails++;
            $display("FAIL stall_hold: tready=%0b valid=%0b data=%0d want 0 1 %0d",
              s_tready, m_tvalid, m_tdata, held); end
        end
        @(posedge aclk); #1;
        m_tready = 1'b1;
      end
    join
    drain();
    tests++; if (held !== 32'd1) begin fails++;
      $display("FAIL stall_value: got %0d want 1", held); end
    tests++; if (got32.size() !== 4 || got32 != exp32) begin fails++;
      $display("FAIL stall_beats: got %0d beats want 4 matching model",
        got32.size()); end
    // clear coincident with a forward step
    clr = 1'b1;
    send(-500, -500);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    clr = 1'b0;
    drain();
    tests++; if (got32.size() == 0 || got32[$] !== 0) begin fails++;
      $display("FAIL clear_pos: got %0d want 0",
        got32.size() ? got32[$] : -999); end
    pos32 = 0; pos8 = 0; e32 = 0; e8 = 0;
    flush();
    send(500, -500);
    drain();
    tests++; if (got32.size() !== 1 || got32[0] !== 1) begin fails++;
      $display("FAIL clear_resume: got %0d want 1",
        got32.size() ? got32[0] : -999); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    send(-500, -500);
    send(500, -500);
    send(-500, 500);
    drain();
    m_tready = 1'b0;
    send(-500, -500);
    @(posedge aclk); #1;
    tests++; if (m_tdata !== 32'd2 || err !== 16'd1) begin fails++;
      $display("FAIL pre_reset: got pos=%0d err=%0d want 2 1", m_tdata, err); end
    aresetn = 1'b0;
    #1;
    tests++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0 ||
                 err !== 16'd0) begin fails++;
      $display("FAIL async_reset: got v=%0b d=%0d e=%0d want 0 0 0",
        m_tvalid, m_tdata, err); end
    do_reset();
    send(500, 0);
    send(500, -500);
    send(500, 500);
    drain();
    tests++; if (got32.size() !== 3 || got32[$] !== 1) begin fails++;
      $display("FAIL rearm: got %0d beats last %0d want 3 beats last 1",
        got32.size(), got32.size() ? got32[$] : -999); end
    tests++; if (got32 != exp32) begin fails++;
      $display("FAIL rearm_model: beat stream differs from model"); end
  endtask

  task automatic test_random(int round);
    bit done;
    do_reset();
    ls   = 5'($urandom_range(0, 31));
    inv  = 1'($urandom);
    lo_a = -16'($urandom_range(0, 200));
    hi_a = 16'($urandom_range(0, 200));
    lo_b = -16'($urandom_range(0, 200));
    hi_b = 16'($urandom_range(0, 200));
    if ($urandom_range(0, 5) == 0) begin
      lo_b = 16'sd150; hi_b = -16'sd150;
    end
    done = 0;
    fork
      begin
        int ph, r, a, b;
        ph = 0;
        for (int i = 0; i < 300; i++) begin
          r = $urandom_range(0, 9);
          if (r < 4) ph = (ph + 1) % 4;
          else if (r < 6) ph = (ph + 3) % 4;
          else if (r == 8) ph = (ph + 2) % 4;
          else if (r == 9) ph = $urandom_range(0, 3);
          a = (ph == 1 || ph == 2) ? int'(hi_a) + 1 + $urandom_range(0, 299)
                                   : int'(lo_a) - 1 - $urandom_range(0, 299);
          b = (ph == 2 || ph == 3) ? int'(hi_b) + 1 + $urandom_range(0, 299)
                                   : int'(lo_b) - 1 - $urandom_range(0, 299);
          if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 800) - 400;
          send(a, b);
          if ($urandom_range(0, 5) == 0) begin
            @(posedge aclk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    tests++; if (got32 != exp32) begin fails++;
      $display("FAIL rand%0d_pos32: got %0d beats want %0d (or data differs)",
        round, got32.size(), exp32.size()); end
    tests++; if (got8 != exp8) begin fails++;
      $display("FAIL rand%0d_pos8: got %0d beats want %0d (or data differs)",
        round, got8.size(), exp8.size()); end
    tests++; if (int'(err) !== e32 || int'(err8) !== e8) begin fails++;
      $display("FAIL rand%0d_err: got %0d/%0d want %0d/%0d",
        round, err, err8, e32, e8); end
    lo_a = -16'sd100; hi_a = 16'sd100;
    lo_b = -16'sd100; hi_b = 16'sd100;
    ls = 5'd0; inv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sine(1'b0, 1'b0, 12);
    test_sine(1'b1, 1'b0, -12);
    test_sine(1'b1, 1'b1, 12);
    test_error_sat();
    test_pos_saturate();
    test_backpressure();
    test_midstream_reset();
    for (int r = 0; r < 6; r++) test_random(r);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quadrature_tracker.md
QUADRATURE_TRACKER -- requirements
Module: quadrature_tracker

Interface
REQ-001 Parameter S_AXIS_TDATA_WIDTH, default 32: input word width; two signed channels of S_AXIS_TDATA_WIDTH/2 bits each (A = low half, B = high half).
REQ-002 Parameter M_AXIS_TDATA_WIDTH, default 32: signed position width.
REQ-003 Parameter ERR_WIDTH, default 16: error counter width.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 FC_lower_threshold_a, FC_upper_threshold_a  in  S/2 each  signed hysteresis thresholds, channel A.
REQ-007 FC_lower_threshold_b, FC_upper_threshold_b  in  S/2 each  signed hysteresis thresholds, channel B.
REQ-008 FC_log_scale  in  5  step = 2^FC_log_scale.
REQ-009 FC_invert  in  1  swaps count direction.
REQ-010 FC_clear  in  1  synchronous clear of position and error count, level-sensitive.
REQ-011 S_AXIS_tvalid / S_AXIS_tready / S_AXIS_tdata  in / out / in  1 / 1 / S  sample stream.
REQ-012 M_AXIS_tvalid / M_AXIS_tready / M_AXIS_tdata  out / in / out  1 / 1 / M  position stream.
REQ-013 error_count  out  ERR_WIDTH  count of illegal quadrature transitions.

Function
REQ-014 Pipeline advance enable en = ~M_AXIS_tvalid | M_AXIS_tready; S_AXIS_tready SHALL equal en, combinationally.
REQ-015 Stage 1 (on en & S_AXIS_tvalid): per channel, bit <= 1 if sample > upper; bit <= 0 if sample < lower; otherwise hold; comparisons signed.
REQ-016 Per channel, armed flag SHALL set on first threshold crossing and stay set until reset.
REQ-017 Stage 2: quadrature state q = {B,A}, Gray order 00 -> 01 -> 11 -> 10 -> 00 = forward.
REQ-018 Both armed, q differs from previous q by one bit in forward order: position += step; reverse order: position -= step; FC_invert swaps signs.
REQ-019 Both bits changed in one sample: no position change; error_count += 1, saturating at all-ones.
REQ-020 Until both channels armed: previous q tracks current q, no counting, no errors.
REQ-021 Position arithmetic SHALL saturate at signed max/min of M_AXIS_TDATA_WIDTH; no wrap-around.
REQ-022 FC_log_scale >= M_AXIS_TDATA_WIDTH-1: step clamps to 2^(M_AXIS_TDATA_WIDTH-2).
REQ-023 Every accepted input sample SHALL produce exactly one output beat carrying updated position; latency 2 cycles with M_AXIS_tready high.
REQ-024 M_AXIS_tvalid/tdata SHALL hold stable while M_AXIS_tvalid & ~M_AXIS_tready.
REQ-025 FC_clear high: position and error_count forced to 0, overrides a same-cycle count or error; armed flags and q unaffected; stream flow unaffected.
REQ-026 If upper < lower (misconfiguration): comparator SHALL hold bit; no counting from that channel.

Reset
REQ-027 On aresetn low: position 0, error_count 0, channel bits 0, armed flags 0, previous q 00, all stage valids 0, M_AXIS_tvalid 0; asserts mid-transfer drop in-flight beats.
REQ-028 Deassertion SHALL be synchronised to aclk externally; first sample accepted the cycle after release.

Structure
REQ-029 Shared package: Gray state encodings, forward/reverse transition lookup, count-direction constants.
REQ-030 One sub-module, hysteresis_comparator (sample, thresholds, enable -> bit, armed), instantiated per channel.
REQ-031 Target size 150-300 RTL lines; no multipliers; step formed by shift.

Verification
REQ-032 Thresholds +-100, log_scale 0; A/B sine 90 deg apart, 3 full forward cycles -> position 12, error_count 0.
REQ-033 Same stimulus, B leading A by 90 deg, FC_invert 0 -> position -12; FC_invert 1 -> +12.
REQ-034 Jump q 00 -> 11 in one sample -> position unchanged, error_count 1; repeated 2^ERR_WIDTH+5 times -> holds all-ones.
REQ-035 M width 8, log_scale 5, 10 forward steps -> position saturates at 127, never negative.
REQ-036 M_AXIS_tready held low 5 cycles -> S_AXIS_tready low, tdata stable, no beats lost; FC_clear same cycle as forward step -> position 0.
REQ-037 aresetn pulsed low mid-stream -> all outputs 0 within same cycle, counting resumes only after both channels re-arm.
